// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between NREQ byte
// producers. It captures the winning requester's byte, acknowledges it,
// strobes the transmitter, then waits for the transmitter to take and
// finish the frame before arbitrating again.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   defined   : a 16-bit watchdog runs from the start strobe to the end of the
//               frame; on expiry timeout_err pulses and the arbiter returns to IDLE.
//   undefined : no watchdog is built, timeout_err is tied low, and the wait
//               states wait indefinitely.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 65535,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_ACC  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  // After reset the pointer sits on the last requester so requester 0 wins first.
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NREQ - 1);

  // Reject parameter values the hardware cannot represent.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must fit the 16-bit watchdog");
  end

  logic [2:0]        state;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   winner;
  logic [NREQ-1:0]   win_onehot;
  logic [DATA_W-1:0] win_data;
  logic              found;
  logic              tmo_fire;

  // Round-robin search: first requester at or after last+1, wrapping modulo NREQ.
  always_comb begin
    winner     = '0;
    found      = 1'b0;
    win_onehot = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int               sum;
      logic [ID_W-1:0]  cand;
      sum = int'(last) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = ID_W'(sum);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    win_onehot[winner] = 1'b1;
    win_data = req_data[winner*DATA_W +: DATA_W];
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tmo_cnt;

  // Expiry only counts while the awaited tx_busy edge has not shown up.
  assign tmo_fire = (tmo_cnt >= TMO_LAST) &&
                    (((state == ST_WAIT_ACC)  && !tx_busy) ||
                     ((state == ST_WAIT_DONE) &&  tx_busy));

  // Watchdog counter cleared at the start strobe, running through both wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      if (state == ST_START) begin
        tmo_cnt <= '0;
      end else if ((state == ST_WAIT_ACC || state == ST_WAIT_DONE) && !tmo_fire) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main sequencer: every output is registered and updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last     <= LAST_RST;
      grant_id <= '0;
      tx_data  <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      arb_busy <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant_id <= winner;
            last     <= winner;
            tx_data  <= win_data;
            ack      <= win_onehot;
            arb_busy <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_start <= 1'b1;
          state    <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT_ACC;
        end
        ST_WAIT_ACC: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_fire) begin
            arb_busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy || tmo_fire) begin
            arb_busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between up to `NREQ` byte producers. It captures one requester's byte, hands it to the transmitter with a one-cycle start strobe, and holds off further grants until the transmitter has accepted and finished the frame. It sits directly in front of the UART TX path and is the only block that drives its start and data inputs.

## Interface
- `NREQ`, 4, number of requesters, 2..8; `ID_W = $clog2(NREQ)` is a localparam.
- `DATA_W`, 8, byte width.
- `TIMEOUT`, 65535, maximum cycles allowed from `tx_start` until the end of the frame; counter width is 16 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level; held high until that requester's `ack`.
- `req_data`  in  NREQ*DATA_W  packed bytes; requester i uses bits `[i*DATA_W +: DATA_W]`; valid whenever `req[i]`=1.
- `ack`  out  NREQ  one-hot, one-cycle capture acknowledge.
- `tx_data`  out  DATA_W  byte presented to the transmitter.
- `tx_start`  out  1  one-cycle start strobe to the transmitter.
- `tx_busy`  in  1  transmitter busy; rises at most 2 cycles after `tx_start` and falls when the frame completes.
- `grant_id`  out  ID_W  index of the current or last granted requester.
- `arb_busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle error pulse (see Configuration).

## Operation
- States: IDLE, LOAD, START, WAIT_ACC, WAIT_DONE.
- IDLE: if `req` != 0, pick the winner by round robin. Search starts at `last+1` and wraps modulo NREQ. On that edge:
  - `grant_id` <= winner, `last` <= winner.
  - `tx_data` <= the winner's byte.
  - Go to LOAD.
- LOAD: `ack[grant_id]`=1 for exactly this cycle. Go to START.
- START: `tx_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_ACC.
- WAIT_ACC: wait for `tx_busy`=1, then go to WAIT_DONE. A `tx_busy` that is already high on entry is accepted immediately.
- WAIT_DONE: wait for `tx_busy`=0, then go to IDLE.
- Request changes after the arbitration decision in IDLE are ignored until the arbiter returns to IDLE.
- A requester that keeps `req` high after its `ack` is treated as a new request in the next IDLE arbitration.
- `tx_data` is stable from LOAD until the next IDLE->LOAD transition.
- Reset values:
  - state = IDLE, `last` = NREQ-1, so requester 0 has first priority.
  - `ack` = 0, `tx_start` = 0, `tx_data` = 0, `grant_id` = 0, `arb_busy` = 0, `timeout_err` = 0.
- Reset mid-frame: the arbiter returns to IDLE on the next edge and drops any pending `ack`/`tx_start`. The transmitter's frame is not cancelled. The arbiter may re-grant while `tx_busy` is still high; the transmitter must ignore `tx_start` while busy.
- All outputs are registered.

## Timing
- `req[i]` high in cycle N (arbiter in IDLE):
  - `ack[i]` and valid `tx_data` in cycle N+1.
  - `tx_start` in cycle N+2.
- Minimum turnaround from `tx_busy` falling (sampled low in WAIT_DONE) to the next `ack` is 2 cycles: IDLE, then LOAD.
- Back-to-back bytes therefore add 4 cycles of overhead per frame beyond the transmitter's busy time.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT_ACC and WAIT_DONE.
  - When it reaches `TIMEOUT` without the expected `tx_busy` edge, `timeout_err`=1 for one cycle and the arbiter returns to IDLE.
  - The rotation pointer still advances past the timed-out requester.
- Not defined:
  - No counter is built and `timeout_err` is tied to 0.
  - WAIT_ACC and WAIT_DONE wait indefinitely.

## Test plan
- Reset, then `req`=4'b0001, `req_data[7:0]`=8'hA5. The transmitter model raises `tx_busy` 1 cycle after `tx_start` and holds it 20 cycles. Expect:
  - `ack`=4'b0001 one cycle after `req`.
  - `tx_start` one cycle later, with `tx_data`=8'hA5.
  - `arb_busy` falls 1 cycle after `tx_busy` falls.
- `req`=4'b1111 held continuously, with bytes 8'h10/8'h11/8'h12/8'h13. Expect grants in order 0,1,2,3,0, and `tx_data` following those values.
- After a grant to 2, set `req`=4'b0101. Expect the next grant to be 0 (wrap past 3), then 2.
- Assert `reset` for 1 cycle during WAIT_DONE with `tx_busy`=1. Expect all outputs at reset values on the next cycle, and the next grant to go to requester 0.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT`=50, the model never raises `tx_busy`. Expect:
  - `timeout_err` pulses exactly 1 cycle, 50 cycles after WAIT_ACC entry.
  - IDLE on the next cycle, and the next grant goes to the following requester.
- Change `req` during WAIT_DONE. Expect no `ack` and no change to `tx_data` until `tx_busy` falls.
